// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller with a byte-lane data RAM and an optional MMIO req/ack bridge.
// Define DMEM_MMIO_EN to enable the MMIO window decode, the IDLE/WAIT FSM and the mmio_* ports.
module dmem_ctrl #(
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter logic [31:0] MMIO_MASK = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mem_wea,
  input  logic        mem_rea,
  input  logic [3:0]  mem_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_hold,
  output logic        mmio_req,
  output logic        mmio_we,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic [3:0]  mmio_be,
  input  logic [31:0] mmio_rdata,
  input  logic        mmio_ack
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  logic          is_mmio;
  logic          ram_wr;
  logic          ram_rd;
  logic          mmio_rd_done;
  logic [AW-1:0] ram_idx;
  logic [31:0]   wrot;
  logic [31:0]   rd_q;
  logic [31:0]   ram [RAM_WORDS];

  assign ram_idx = mem_addr[2 +: AW];

  // Store data is right-justified; rotate it so each byte lands in its addressed lane.
  // NOTE: every variable assigned in always_comb gets a value on every path (default or full case), otherwise a latch is inferred.
  always_comb begin
    case (mem_addr[1:0])
      2'd0:    wrot = mem_din;
      2'd1:    wrot = {mem_din[23:0], mem_din[31:24]};
      2'd2:    wrot = {mem_din[15:0], mem_din[31:16]};
      default: wrot = {mem_din[7:0],  mem_din[31:8]};
    endcase
  end

  // A simultaneous store and load is illegal; the store wins and the read register is left alone.
  assign ram_wr = mem_wea & ~is_mmio;
  assign ram_rd = mem_rea & ~mem_wea & ~is_mmio;

  // NOTE: the RAM array has no reset so it maps onto block RAM; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_en[i]) ram[ram_idx][8*i +: 8] <= wrot[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      rd_q <= '0;
    end else if (ram_rd) begin
      rd_q <= ram[ram_idx];
    end else if (mmio_rd_done) begin
      rd_q <= mmio_rdata;
    end
  end

  assign mem_dout = rd_q;

`ifdef DMEM_MMIO_EN

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        acc_valid;
  logic        issue;
  logic        done;
  logic        hold;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  assign acc_valid = mem_wea | mem_rea;
  assign is_mmio   = (mem_addr & MMIO_MASK) == MMIO_BASE;

  always_comb begin
    state_nxt = state;
    hold      = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc_valid && is_mmio) begin
          hold      = 1'b1;
          issue     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Request inputs are frozen while held, so the pipeline is released exactly on the ack cycle.
        hold = ~mmio_ack;
        if (mmio_ack) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state   <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        req_q   <= 1'b1;
        we_q    <= mem_wea;
        addr_q  <= mem_addr;
        wdata_q <= wrot;
        be_q    <= mem_en;
      end else if (done) begin
        req_q <= 1'b0;
      end
    end
  end

  assign mmio_rd_done = done & ~we_q;
  assign mem_hold     = hold;
  assign mmio_req     = req_q;
  assign mmio_we      = we_q;
  assign mmio_addr    = addr_q;
  assign mmio_wdata   = wdata_q;
  assign mmio_be      = be_q;

`else

  // Without the bridge every address, including the MMIO window, aliases into the RAM.
  logic unused_mmio;

  assign is_mmio      = 1'b0;
  assign mmio_rd_done = 1'b0;
  assign mem_hold     = 1'b0;
  assign mmio_req     = 1'b0;
  assign mmio_we      = 1'b0;
  assign mmio_addr    = '0;
  assign mmio_wdata   = '0;
  assign mmio_be      = '0;
  assign unused_mmio  = ^{mmio_rdata, mmio_ack, mem_addr[31:AW+2], MMIO_BASE, MMIO_MASK};

`endif

endmodule
